// File: rtl/reg_wb_dest_pipe.sv
// Writeback-destination pipeline with a pending-write scoreboard.
// Picks rd/rt/link at issue and carries {en, addr} to writeback.
module reg_wb_dest_pipe #(
  parameter int AW       = 5,
  parameter int STAGES   = 3,
  parameter int LINK_REG = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic          i_alu_op,
  input  logic          i_imm_op,
  input  logic          i_mem_op,
  input  logic          i_write_op,
  input  logic          i_link_op,
  input  logic [AW-1:0] i_rt,
  input  logic [AW-1:0] i_rd,
  input  logic          i_stall,
  input  logic          i_flush,
  input  logic [AW-1:0] i_q0_addr,
  input  logic [AW-1:0] i_q1_addr,
  output logic          o_q0_busy,
  output logic          o_q1_busy,
  output logic          o_wb_en,
  output logic [AW-1:0] o_wb_addr,
  output logic [3:0]    o_pending
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [STAGES-1:0]         en_q, en_d;
  logic [STAGES-1:0][AW-1:0] addr_q, addr_d;

  logic          wr_sel;
  logic [AW-1:0] dest;
  logic          new_en;
  logic          b0, b1;
  logic [3:0]    pend;

  always_comb begin
    wr_sel = 1'b0;
    dest   = '0;
    if (i_link_op) begin
      wr_sel = 1'b1;
      dest   = LINK_A;
    end else if (i_mem_op && !i_write_op) begin
      wr_sel = 1'b1;
      dest   = i_rt;
    end else if (i_alu_op && i_imm_op) begin
      wr_sel = 1'b1;
      dest   = i_rt;
    end else if (i_alu_op) begin
      wr_sel = 1'b1;
      dest   = i_rd;
    end
  end

  assign new_en = i_valid & wr_sel & (dest != '0);

  // Flush clears every younger entry; the oldest still retires unless stalled.
  always_comb begin
    en_d   = en_q;
    addr_d = addr_q;
    if (!i_stall) begin
      for (int n = STAGES - 1; n > 0; n--) begin
        en_d[n]   = en_q[n-1];
        addr_d[n] = addr_q[n-1];
      end
      en_d[0]   = new_en;
      addr_d[0] = dest;
    end
    if (i_flush) begin
      for (int n = 0; n < STAGES - 1; n++) begin
        en_d[n] = 1'b0;
      end
      if (!i_stall) begin
        en_d[STAGES-1] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      addr_q <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    b0   = 1'b0;
    b1   = 1'b0;
    pend = '0;
    for (int n = 0; n < STAGES; n++) begin
      if (en_q[n] && (addr_q[n] == i_q0_addr)) b0 = 1'b1;
      if (en_q[n] && (addr_q[n] == i_q1_addr)) b1 = 1'b1;
      pend = pend + 4'(en_q[n]);
    end
  end

  assign o_q0_busy = b0 & (i_q0_addr != '0);
  assign o_q1_busy = b1 & (i_q1_addr != '0);
  assign o_wb_en   = en_q[STAGES-1] & ~i_stall;
  assign o_wb_addr = addr_q[STAGES-1];
  assign o_pending = pend;

endmodule
